// File: rtl/lenet_pool_if.sv
// lenet_pool_if: frame pixel stream in, LeNet input-memory write port out.
// The pooling block connects through the slave modport; the frame source and
// memory side connect through the master modport.
interface lenet_pool_if;
    logic       frame_start;
    logic       pixel_valid;
    logic [3:0] frame_pixel;
    logic       lenet_busy;
    logic [9:0] lenet_addr;
    logic [7:0] lenet_data;
    logic       lenet_we;
    logic       lenet_start;
    logic       capture_active;

    modport master (
        output frame_start, pixel_valid, frame_pixel, lenet_busy,
        input  lenet_addr, lenet_data, lenet_we, lenet_start, capture_active
    );

    modport slave (
        input  frame_start, pixel_valid, frame_pixel, lenet_busy,
        output lenet_addr, lenet_data, lenet_we, lenet_start, capture_active
    );
endinterface

// File: rtl/lenet_pool.sv
// lenet_pool: crops the centred window out of the raster pixel stream,
// averages each widthlength x heightlength block into one 8-bit sample and
// writes the lenet_size x lenet_size image row-major into the LeNet input
// memory, then pulses lenet_start.
// Build option: define LENET_POOL_INVERT_EN to accumulate 15 - pixel instead
// of the raw pixel (dark ink on white paper -> light digit on dark ground).
module lenet_pool #(
    parameter int widthlength  = 8,
    parameter int heightlength = 8,
    parameter int lenet_size   = 28,
    parameter int hRez         = 640,
    parameter int vRez         = 480
) (
    input  logic        clk25,
    input  logic        rst_n,
    lenet_pool_if.slave bus
);
    localparam int left  = hRez / 2 - widthlength * lenet_size / 2;
    localparam int upper = vRez / 2 - heightlength * lenet_size / 2;
    localparam int CW    = (lenet_size > 1) ? $clog2(lenet_size) : 1;

    localparam logic [9:0] X_LO  = 10'(left);
    localparam logic [9:0] X_HI  = 10'(left + widthlength * lenet_size);
    localparam logic [8:0] Y_LO  = 9'(upper);
    localparam logic [8:0] Y_HI  = 9'(upper + heightlength * lenet_size);
    localparam logic [9:0] X_MAX = 10'(hRez - 1);
    localparam logic [8:0] Y_END = 9'(vRez);
    localparam logic [9:0] WL    = 10'(widthlength);
    localparam logic [8:0] HL    = 9'(heightlength);
    localparam logic [9:0] LSZ   = 10'(lenet_size);
    localparam logic [9:0] LAST  = 10'(lenet_size * lenet_size - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE, SKIP} state_t;

    state_t                     state_q;
    logic [9:0]                 x_q;
    logic [8:0]                 y_q;
    logic [lenet_size-1:0][9:0] acc_q;
    logic [9:0]                 addr_q;
    logic [7:0]                 data_q;
    logic                       we_q;
    logic                       start_q;
    logic                       cap_q;

    logic [3:0]    pix;
    logic [9:0]    dx;
    logic [8:0]    dy;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [9:0]    sum;
    logic          in_win;
    logic          acc_en;
    logic          blk_done;

    // Window position, running block sum and block-completion detect
    always_comb begin
`ifdef LENET_POOL_INVERT_EN
        pix = 4'd15 - bus.frame_pixel;
`else
        pix = bus.frame_pixel;
`endif
        dx       = x_q - X_LO;
        dy       = y_q - Y_LO;
        col      = CW'(dx / WL);
        row      = CW'(dy / HL);
        in_win   = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);
        // a pixel arriving with frame_start belongs to no frame
        acc_en   = (state_q == CAPTURE) && bus.pixel_valid && !bus.frame_start && in_win;
        sum      = acc_q[col] + 10'(pix);
        blk_done = acc_en && ((dx % WL) == (WL - 10'd1)) && ((dy % HL) == (HL - 9'd1));
    end

    // Raster counters and per-column block accumulators
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
        end else if (bus.frame_start) begin
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
        end else if (bus.pixel_valid && (y_q < Y_END)) begin
            if (x_q == X_MAX) begin
                x_q <= '0;
                y_q <= y_q + 9'd1;
            end else begin
                x_q <= x_q + 10'd1;
            end
            // the completing pixel is folded into the write, so the column restarts at 0
            if (acc_en) acc_q[col] <= blk_done ? '0 : sum;
        end
    end

    // Frame control FSM with registered write, start and capture outputs
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            start_q <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            start_q <= 1'b0;
            if (bus.frame_start) begin
                // new frame from any state; an unfinished capture is dropped
                state_q <= bus.lenet_busy ? SKIP : CAPTURE;
                cap_q   <= !bus.lenet_busy;
            end else begin
                case (state_q)
                    CAPTURE: begin
                        if (blk_done) begin
                            we_q   <= 1'b1;
                            addr_q <= 10'(row) * LSZ + 10'(col);
                            data_q <= sum[9:2];
                        end
                        if (we_q && (addr_q == LAST)) begin
                            state_q <= DONE;
                            start_q <= 1'b1;
                            cap_q   <= 1'b0;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign bus.lenet_addr     = addr_q;
    assign bus.lenet_data     = data_q;
    assign bus.lenet_we       = we_q;
    assign bus.lenet_start    = start_q;
    assign bus.capture_active = cap_q;
endmodule

// File: tb/tb_lenet_pool.sv
// tb_lenet_pool: directed frames against a scaled-down lenet_pool
// (4x4 output, 64x48 raster, 8x8 blocks) so whole frames stay short.
// Window is x in [16,48), y in [8,40); addresses 0..15.
module tb_lenet_pool;
    localparam int WL = 8;
    localparam int HL = 8;
    localparam int LS = 4;
    localparam int HR = 64;
    localparam int VR = 48;
    localparam int L  = HR / 2 - WL * LS / 2;
    localparam int U  = VR / 2 - HL * LS / 2;
    localparam int NB = LS * LS;
    localparam int FR = HR * VR;

    logic clk25 = 1'b0;
    logic rst_n = 1'b0;

    lenet_pool_if bus ();

    lenet_pool #(
        .widthlength (WL),
        .heightlength(HL),
        .lenet_size  (LS),
        .hRez        (HR),
        .vRez        (VR)
    ) dut (
        .clk25(clk25),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #20 clk25 = ~clk25;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int wa[$];
    int wd[$];
    int nstart = 0;
    int ncap = 0;
    int wr0_cyc = 0;
    int lastwr_cyc = 0;
    int start_cyc = 0;
    int drv_cyc = 0;

    always @(posedge clk25) cyc <= cyc + 1;

    // write/start/capture monitor, sampled mid-cycle
    always @(negedge clk25) begin
        if (bus.lenet_we) begin
            wa.push_back(int'(bus.lenet_addr));
            wd.push_back(int'(bus.lenet_data));
            if (bus.lenet_addr == 10'd0) wr0_cyc <= cyc;
            lastwr_cyc <= cyc;
        end
        if (bus.lenet_start) begin
            nstart    <= nstart + 1;
            start_cyc <= cyc;
        end
        if (bus.capture_active) ncap <= ncap + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: all 15, mode 1: only the window's top-left pixel is 15, mode 2: all 8
    function automatic logic [3:0] pv(input int mode, input int x, input int y);
        case (mode)
            0:       return 4'd15;
            1:       return (x == L && y == U) ? 4'd15 : 4'd0;
            default: return 4'd8;
        endcase
    endfunction

    function automatic int ed(input int mode, input int a);
`ifdef LENET_POOL_INVERT_EN
        case (mode)
            0:       return 0;
            1:       return (a == 0) ? 236 : 240;
            default: return 112;
        endcase
`else
        case (mode)
            0:       return 240;
            1:       return (a == 0) ? 3 : 0;
            default: return 128;
        endcase
`endif
    endfunction

    // optional frame_start, then npix raster pixels at a 1-in-duty rate
    task automatic run(input int mode, input bit busy, input int npix, input int duty, input bit fs);
        if (fs) begin
            bus.lenet_busy  = busy;
            bus.frame_start = 1'b1;
            @(posedge clk25); #1;
            bus.frame_start = 1'b0;
        end
        for (int i = 0; i < npix; i++) begin
            int x;
            int y;
            x = i % HR;
            y = i / HR;
            if (i == npix / 2) bus.lenet_busy = 1'b0;
            bus.pixel_valid = 1'b1;
            bus.frame_pixel = pv(mode, x, y);
            if (x == L + WL - 1 && y == U + HL - 1) drv_cyc = cyc;
            @(posedge clk25); #1;
            bus.pixel_valid = 1'b0;
            for (int k = 1; k < duty; k++) begin
                @(posedge clk25); #1;
            end
        end
        bus.pixel_valid = 1'b0;
        repeat (4) begin
            @(posedge clk25); #1;
        end
    endtask

    task automatic chk_frame(input string tag, input int base, input int mode, input int nexp);
        int ba;
        int bd;
        ba = 0;
        bd = 0;
        chk({tag, ".nwr"}, wa.size() - base, nexp);
        for (int i = base; i < wa.size(); i++) begin
            if (wa[i] != i - base) ba++;
            if (wd[i] != ed(mode, wa[i])) bd++;
        end
        chk({tag, ".addr_bad"}, ba, 0);
        chk({tag, ".data_bad"}, bd, 0);
    endtask

    initial begin
        int b;
        int s;
        int c;
        bus.frame_start = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.frame_pixel = 4'd0;
        bus.lenet_busy  = 1'b0;

        #50;
        chk("rst.addr",  int'(bus.lenet_addr), 0);
        chk("rst.data",  int'(bus.lenet_data), 0);
        chk("rst.we",    int'(bus.lenet_we), 0);
        chk("rst.start", int'(bus.lenet_start), 0);
        chk("rst.cap",   int'(bus.capture_active), 0);
        @(posedge clk25); #1;
        rst_n = 1'b1;

        // constant 15, full frame
        b = wa.size(); s = nstart; c = ncap;
        run(0, 1'b0, FR, 1, 1'b1);
        chk_frame("t1", b, 0, NB);
        chk("t1.start", nstart - s, 1);
        chk("t1.start_lat", start_cyc - lastwr_cyc, 1);
        chk("t1.cap_seen", int'(ncap > c), 1);
        chk("t1.cap_idle", int'(bus.capture_active), 0);

        // single bright pixel at the window origin
        b = wa.size(); s = nstart;
        run(1, 1'b0, FR, 1, 1'b1);
        chk_frame("t2", b, 1, NB);
        chk("t2.start", nstart - s, 1);
        chk("t2.wr_lat", wr0_cyc - drv_cyc, 1);

        // busy at frame_start: frame skipped, busy drop mid-frame ignored
        b = wa.size(); s = nstart; c = ncap;
        run(0, 1'b1, FR, 1, 1'b1);
        chk("t3.nwr", wa.size() - b, 0);
        chk("t3.start", nstart - s, 0);
        chk("t3.cap", ncap - c, 0);

        // abort inside block row 2, then a full frame of 8s
        b = wa.size(); s = nstart;
        run(0, 1'b0, (U + 2 * HL + 4) * HR + L + 14, 1, 1'b1);
        chk_frame("t4a", b, 0, 2 * LS);
        chk("t4a.start", nstart - s, 0);
        b = wa.size(); s = nstart;
        run(2, 1'b0, FR, 1, 1'b1);
        chk_frame("t4b", b, 2, NB);
        chk("t4b.start", nstart - s, 1);

        // 1-in-3 pixel_valid duty
        b = wa.size(); s = nstart;
        run(2, 1'b0, FR, 3, 1'b1);
        chk_frame("t5", b, 2, NB);
        chk("t5.start", nstart - s, 1);

        // async reset in the middle of address 9's block
        b = wa.size();
        run(0, 1'b0, (U + 2 * HL + 2) * HR + L + 12, 1, 1'b1);
        chk_frame("t6a", b, 0, 2 * LS);
        #5;
        rst_n = 1'b0;
        #1;
        chk("t6.addr",  int'(bus.lenet_addr), 0);
        chk("t6.data",  int'(bus.lenet_data), 0);
        chk("t6.we",    int'(bus.lenet_we), 0);
        chk("t6.start", int'(bus.lenet_start), 0);
        chk("t6.cap",   int'(bus.capture_active), 0);
        b = wa.size(); s = nstart; c = ncap;
        @(posedge clk25); #1;
        rst_n = 1'b1;
        run(0, 1'b0, 1000, 1, 1'b0);
        chk("t6.nwr", wa.size() - b, 0);
        chk("t6.start_after", nstart - s, 0);
        chk("t6.cap_after", ncap - c, 0);

        // fresh frame_start after reset recovers
        b = wa.size(); s = nstart;
        run(2, 1'b0, FR, 1, 1'b1);
        chk_frame("t7", b, 2, NB);
        chk("t7.start", nstart - s, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
